// File: rtl/ps2_key_tracker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ps2_key_tracker
//   PS/2 scancode decoder for the synth keyboard front end. Consumes bytes
//   from the PS/2 receiver, resolves F0 (break) / E0 (extended) prefixes,
//   keeps a held-key bitmap for NUM_KEYS mapped keys and queues press/release
//   events in a small FIFO drained through a valid/ready handshake.
//
//   Optional feature macro: PS2_EXT_KEYS_EN
//     defined   : E0-prefixed codes are matched against KEY_MAP like plain codes
//     undefined : the byte after an E0 prefix is consumed with no action
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   RESET_N       in   asynchronous active-low reset
//   CODE_VALID    in   one-cycle strobe, CODEWORD holds a new byte
//   CODEWORD      in   [7:0] scancode byte
//   ALL_OFF       in   synchronous panic: release all, flush FIFO, clear prefix
//   teclas        out  [NUM_KEYS-1:0] held-key bitmap
//   evt_valid     out  FIFO not empty
//   evt_ready     in   consumer accepts head event
//   evt_key       out  [KEY_W-1:0] head event key index
//   evt_press     out  head event type (1 = press, 0 = release)
//   evt_overflow  out  sticky: an event was dropped on a full FIFO
// ---------------------------------------------------------------------------
module ps2_key_tracker #(
  parameter int                    NUM_KEYS  = 8,
  parameter logic [8*NUM_KEYS-1:0] KEY_MAP   = 64'h423B33342B231B1C,
  parameter int                    EVT_DEPTH = 4,
  localparam int                   KEY_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                CODE_VALID,
  input  logic [7:0]          CODEWORD,
  input  logic                ALL_OFF,
  output logic [NUM_KEYS-1:0] teclas,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KEY_W-1:0]    evt_key,
  output logic                evt_press,
  output logic                evt_overflow
);

  localparam int PTR_W = $clog2(EVT_DEPTH);

`ifdef PS2_EXT_KEYS_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_KEYS-1:0]   r_teclas;
  logic                  r_overflow;
  logic [PTR_W:0]        r_wr_ptr;
  logic [PTR_W:0]        r_rd_ptr;
  logic [KEY_W-1:0]      r_mem_key   [EVT_DEPTH];
  logic                  r_mem_press [EVT_DEPTH];

  logic                  w_ignore;
  logic                  w_is_f0;
  logic                  w_is_e0;
  logic                  w_do_make;
  logic                  w_do_break;
  logic                  w_hit;
  logic [KEY_W-1:0]      w_idx;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_en;

  // Byte classification: prefixes and protocol bytes that never affect state
  always_comb begin
    w_is_f0  = (CODEWORD == 8'hF0);
    w_is_e0  = (CODEWORD == 8'hE0);
    case (CODEWORD)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: w_ignore = 1'b1;
      default:                                  w_ignore = 1'b0;
    endcase
  end

  // Key lookup; scanning downwards leaves the lowest matching index
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (CODEWORD == KEY_MAP[8*i +: 8]) begin
        w_hit = 1'b1;
        w_idx = i[KEY_W-1:0];
      end else begin
        w_hit = w_hit;
      end
    end
  end

  // Prefix FSM next state and make/break decision
  always_comb begin
    w_state_nxt = r_state;
    w_do_make   = 1'b0;
    w_do_break  = 1'b0;
    if (CODE_VALID && !w_ignore) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_f0)      w_state_nxt = ST_BRK;
          else if (w_is_e0) w_state_nxt = ST_EXT;
          else              w_do_make   = 1'b1;
        end
        ST_BRK: begin
          if (w_is_f0)      w_state_nxt = ST_BRK;
          else if (w_is_e0) w_state_nxt = ST_EXT_BRK;
          else begin
            w_do_break  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (w_is_f0)      w_state_nxt = ST_EXT_BRK;
          else if (w_is_e0) w_state_nxt = ST_EXT;
          else begin
            w_do_make   = EXT_EN;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (w_is_f0 || w_is_e0) w_state_nxt = ST_EXT_BRK;
          else begin
            w_do_break  = EXT_EN;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Event generation and FIFO bookkeeping; a pop frees a slot for a same-cycle push
  always_comb begin
    w_push  = w_hit && ((w_do_make && !r_teclas[w_idx]) || (w_do_break && r_teclas[w_idx]));
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
              (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    w_pop   = !w_empty && evt_ready;
    w_wr_en = w_push && (!w_full || w_pop);
  end

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)     r_state <= ST_IDLE;
    else if (ALL_OFF) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Held-key bitmap and sticky overflow flag
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_teclas   <= '0;
      r_overflow <= 1'b0;
    end else if (ALL_OFF) begin
      r_teclas   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_teclas[w_idx] <= w_do_make;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // FIFO pointers, one extra bit separates full from empty
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (ALL_OFF) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      if (w_pop)   r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // FIFO storage
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < EVT_DEPTH; i++) begin
        r_mem_key[i]   <= '0;
        r_mem_press[i] <= 1'b0;
      end
    end else if (w_wr_en && !ALL_OFF) begin
      r_mem_key[r_wr_ptr[PTR_W-1:0]]   <= w_idx;
      r_mem_press[r_wr_ptr[PTR_W-1:0]] <= w_do_make;
    end
  end

  assign teclas       = r_teclas;
  assign evt_valid    = !w_empty;
  assign evt_key      = r_mem_key[r_rd_ptr[PTR_W-1:0]];
  assign evt_press    = r_mem_press[r_rd_ptr[PTR_W-1:0]];
  assign evt_overflow = r_overflow;

endmodule

// File: tb/tb_ps2_key_tracker.sv
`timescale 1ns/1ps
// Randomized bench for ps2_key_tracker with a behavioural reference model:
// prefix flags, a held-key array and an event queue.
module tb_ps2_key_tracker;

  localparam int NUM_KEYS  = 8;
  localparam int EVT_DEPTH = 4;

`ifdef PS2_EXT_KEYS_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic                CLOCK_50;
  logic                RESET_N;
  logic                CODE_VALID;
  logic [7:0]          CODEWORD;
  logic                ALL_OFF;
  logic [NUM_KEYS-1:0] teclas;
  logic                evt_valid;
  logic                evt_ready;
  logic [2:0]          evt_key;
  logic                evt_press;
  logic                evt_overflow;

  ps2_key_tracker dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .CODE_VALID   (CODE_VALID),
    .CODEWORD     (CODEWORD),
    .ALL_OFF      (ALL_OFF),
    .teclas       (teclas),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_key      (evt_key),
    .evt_press    (evt_press),
    .evt_overflow (evt_overflow)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // reference model
  typedef struct { int key; bit press; } evt_t;
  evt_t     m_q[$];
  bit       m_held[NUM_KEYS];
  bit       m_brk;
  bit       m_ext;
  bit       m_ovf;
  bit [7:0] key_codes[NUM_KEYS] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
  bit [7:0] ign_codes[6]        = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_ignored(input bit [7:0] c);
    foreach (ign_codes[i]) if (ign_codes[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lookup(input bit [7:0] c);
    for (int i = 0; i < NUM_KEYS; i++) if (key_codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_q.delete();
    foreach (m_held[i]) m_held[i] = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_clock(input bit v, input bit [7:0] c, input bit rdy, input bit off);
    bit   do_push;
    evt_t e;
    int   k;
    if (off) begin
      model_clear();
      return;
    end
    do_push = 1'b0;
    if (v && !is_ignored(c)) begin
      if (c == 8'hF0)      m_brk = 1'b1;
      else if (c == 8'hE0) m_ext = 1'b1;
      else begin
        k = lookup(c);
        if (k >= 0 && (!m_ext || EXT_EN)) begin
          if (!m_brk && !m_held[k]) begin
            m_held[k] = 1'b1; do_push = 1'b1; e.key = k; e.press = 1'b1;
          end else if (m_brk && m_held[k]) begin
            m_held[k] = 1'b0; do_push = 1'b1; e.key = k; e.press = 1'b0;
          end
        end
        m_brk = 1'b0;
        m_ext = 1'b0;
      end
    end
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < EVT_DEPTH) m_q.push_back(e);
      else m_ovf = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_teclas();
    logic [31:0] t = '0;
    for (int i = 0; i < NUM_KEYS; i++) t[i] = m_held[i];
    return t;
  endfunction

  task automatic compare_all(input string where);
    chk({where, " teclas"}, {24'b0, teclas}, model_teclas());
    chk({where, " evt_valid"}, {31'b0, evt_valid}, {31'b0, m_q.size() > 0});
    chk({where, " evt_overflow"}, {31'b0, evt_overflow}, {31'b0, m_ovf});
    if (m_q.size() > 0 && evt_valid) begin
      chk({where, " evt_key"}, {29'b0, evt_key}, m_q[0].key);
      chk({where, " evt_press"}, {31'b0, evt_press}, {31'b0, m_q[0].press});
    end
  endtask

  task automatic step(input bit v, input bit [7:0] c, input bit rdy, input bit off);
    @(negedge CLOCK_50);
    CODE_VALID = v; CODEWORD = c; evt_ready = rdy; ALL_OFF = off;
    @(posedge CLOCK_50);
    model_clock(v, c, rdy, off);
    #1;
    compare_all("step");
  endtask

  task automatic byte_in(input bit [7:0] c, input bit rdy);
    step(1'b1, c, rdy, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge CLOCK_50);
    RESET_N = 1'b0; CODE_VALID = 1'b0; ALL_OFF = 1'b0; evt_ready = 1'b0;
    #1;
    model_clear();
    compare_all("reset");
    chk("reset evt_key", {29'b0, evt_key}, 32'd0);
    chk("reset evt_press", {31'b0, evt_press}, 32'd0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b1; CODE_VALID = 1'b0; CODEWORD = 8'h00; ALL_OFF = 1'b0; evt_ready = 1'b0;
    model_clear();
    pulse_reset();

    // make, typematic repeats, break
    byte_in(8'h1C, 1'b0);
    chk("t1 teclas", {24'b0, teclas}, 32'h01);
    repeat (3) byte_in(8'h1C, 1'b0);
    byte_in(8'hF0, 1'b0); byte_in(8'h1C, 1'b0);
    chk("t1 released", {24'b0, teclas}, 32'h00);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    // three held keys, then drain in order
    byte_in(8'h1C, 1'b0); byte_in(8'h1B, 1'b0); byte_in(8'h23, 1'b0);
    chk("t2 teclas", {24'b0, teclas}, 32'h07);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

    // overflow and pop+push while full
    byte_in(8'h2B, 1'b0); byte_in(8'h34, 1'b0); byte_in(8'h33, 1'b0);
    byte_in(8'h3B, 1'b0); byte_in(8'h42, 1'b0);
    chk("t3 overflow", {31'b0, evt_overflow}, 32'd1);
    byte_in(8'hF0, 1'b0);
    byte_in(8'h42, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // extended sequences
    step(1'b0, 8'h00, 1'b0, 1'b1);
    byte_in(8'hE0, 1'b0); byte_in(8'h1C, 1'b0);
    byte_in(8'hE0, 1'b0); byte_in(8'hF0, 1'b0); byte_in(8'h1C, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    // pending break lost on reset, ALL_OFF beats CODE_VALID
    byte_in(8'hF0, 1'b0);
    pulse_reset();
    byte_in(8'h1B, 1'b0);
    chk("t5 make after reset", {24'b0, teclas}, 32'h02);
    step(1'b1, 8'h1C, 1'b0, 1'b1);
    chk("t5 alloff", {24'b0, teclas}, 32'h00);

    // break of idle key, unmapped code, ignored byte inside break
    byte_in(8'hF0, 1'b0); byte_in(8'h42, 1'b0);
    byte_in(8'h07, 1'b0);
    byte_in(8'h1C, 1'b0);
    byte_in(8'hF0, 1'b0); byte_in(8'hAA, 1'b0); byte_in(8'h1C, 1'b0);
    chk("t6 brk kept", {24'b0, teclas}, 32'h00);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int       sel;
      bit       v;
      bit [7:0] c;
      bit       rdy;
      bit       off;
      sel = $urandom_range(0, 9);
      v   = 1'b1;
      case (sel)
        0, 1, 2, 3, 4: c = key_codes[$urandom_range(0, NUM_KEYS - 1)];
        5:             c = 8'hF0;
        6:             c = 8'hE0;
        7:             c = ign_codes[$urandom_range(0, 5)];
        8:             c = 8'($urandom_range(0, 255));
        default: begin v = 1'b0; c = 8'($urandom_range(0, 255)); end
      endcase
      rdy = ($urandom_range(0, 9) < 4);
      off = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 699) == 0) pulse_reset();
      else step(v, c, rdy, off);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
